// File: rtl/ex_alu_stage_pkg.sv
// Shared types and constants for the execute-stage arithmetic block.
// Opcode values follow the ALU control encoding produced by the decode stage.
package ex_pkg;

    localparam int XLEN = 64;
    localparam int OPW  = 3;
    localparam int SHW  = $clog2(XLEN);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [OPW-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    // Everything the stage hands downstream, captured together in one register.
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] branch_target;
        logic            take_branch;
        logic [XLEN-1:0] next_pc;
    } ex_out_t;

endpackage

// File: rtl/ex_alu_stage_if.sv
// Operand/result bundle between the pipeline control and the EX arithmetic block.
// en is a stall qualifier: a rising edge with en=1 captures the inputs; with en=0 the outputs hold.
interface ex_alu_stage_if;
    import ex_pkg::*;

    logic                en;
    logic [OPW-1:0]      alu_op;
    logic                alu_src;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
    logic                branch;

    logic [XLEN-1:0]     result;
    logic                zero;
    logic [XLEN-1:0]     pc_plus4;
    logic [XLEN-1:0]     branch_target;
    logic                take_branch;
    logic [XLEN-1:0]     next_pc;

    modport master (
        output en, alu_op, alu_src, rs1_data, rs2_data, imm, pc, branch,
        input  result, zero, pc_plus4, branch_target, take_branch, next_pc
    );

    modport slave (
        input  en, alu_op, alu_src, rs1_data, rs2_data, imm, pc, branch,
        output result, zero, pc_plus4, branch_target, take_branch, next_pc
    );

endinterface

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational 64-bit ALU with zero flag; arithmetic wraps modulo 2^XLEN.
module alu_core
    import ex_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_XOR: result = a ^ b;
            // Only the low SHW bits of B form the shift amount.
            ALU_SLL: result = a << b[SHW-1:0];
            ALU_SRL: result = a >> b[SHW-1:0];
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU, PC+4 and branch-target adders, branch resolution and
// a single output register that presents all results one cycle after the operands.
module ex_alu_stage
    import ex_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_alu_stage_if.slave bus
);

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;
    logic            take_branch;

    ex_out_t out_d;
    ex_out_t out_q;

    assign op_b = bus.alu_src ? bus.imm : bus.rs2_data;

    alu_core u_alu_core (
        .a      (bus.rs1_data),
        .b      (op_b),
        .op     (alu_op_t'(bus.alu_op)),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Branch offsets are in half-words, hence the shift before the add.
    assign pc_plus4      = bus.pc + PC_STEP;
    assign branch_target = bus.pc + (bus.imm << 1);
    assign take_branch   = bus.branch & alu_zero;

    always_comb begin
        out_d = out_q;
        if (bus.en) begin
            out_d.result        = alu_result;
            out_d.zero          = alu_zero;
            out_d.pc_plus4      = pc_plus4;
            out_d.branch_target = branch_target;
            out_d.take_branch   = take_branch;
            out_d.next_pc       = take_branch ? branch_target : pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.result        = out_q.result;
    assign bus.zero          = out_q.zero;
    assign bus.pc_plus4      = out_q.pc_plus4;
    assign bus.branch_target = out_q.branch_target;
    assign bus.take_branch   = out_q.take_branch;
    assign bus.next_pc       = out_q.next_pc;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed and randomized bench for ex_alu_stage against a behavioural reference model.
module tb_ex_alu_stage;
    import ex_pkg::*;

    logic clk;
    logic rst;

    ex_alu_stage_if bus ();

    ex_alu_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    ex_out_t exp_o;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic ex_out_t ref_model(input int op, input logic src,
                                          input logic [63:0] a, input logic [63:0] rs2,
                                          input logic [63:0] im, input logic [63:0] p,
                                          input logic br);
        ex_out_t o;
        logic [63:0] b;
        int unsigned sh;
        b  = src ? im : rs2;
        sh = b % 64;
        case (op)
            0: o.result = a & b;
            1: o.result = a | b;
            2: o.result = a + b;
            3: o.result = a ^ b;
            4: o.result = a << sh;
            5: o.result = a >> sh;
            6: o.result = a - b;
            default: o.result = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
        endcase
        o.zero          = (o.result == 64'd0);
        o.pc_plus4      = p + 64'd4;
        o.branch_target = p + im * 64'd2;
        o.take_branch   = br && o.zero;
        o.next_pc       = o.take_branch ? o.branch_target : o.pc_plus4;
        return o;
    endfunction

    // ---------------- scoreboard checks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".result"},  bus.result,             exp_o.result);
        check({tag, ".zero"},    {63'd0, bus.zero},        {63'd0, exp_o.zero});
        check({tag, ".pc4"},     bus.pc_plus4,           exp_o.pc_plus4);
        check({tag, ".target"},  bus.branch_target,      exp_o.branch_target);
        check({tag, ".take"},    {63'd0, bus.take_branch}, {63'd0, exp_o.take_branch});
        check({tag, ".next_pc"}, bus.next_pc,            exp_o.next_pc);
    endtask

    // ---------------- drivers ----------------
    task automatic apply(input logic e, input int op, input logic src,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic [63:0] p, input logic br);
        bus.en       = e;
        bus.alu_op   = op[2:0];
        bus.alu_src  = src;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.imm      = im;
        bus.pc       = p;
        bus.branch   = br;
    endtask

    task automatic tick(input string tag);
        if (bus.en)
            exp_o = ref_model(int'(bus.alu_op), bus.alu_src, bus.rs1_data, bus.rs2_data,
                              bus.imm, bus.pc, bus.branch);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        exp_o = '0;
        check_all(tag);
        rst = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] held;
        exp_o = '0;
        rst   = 1'b0;
        apply(1'b0, 0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // pre-load nonzero outputs, then reset between edges
        apply(1'b1, 2, 1'b0, 64'd3, 64'd4, 64'd5, 64'h200, 1'b1);
        tick("preload");
        check("preload.nonzero", bus.result, 64'd7);
        async_reset("async_rst");

        // ADD / SUB with zero flag
        apply(1'b1, 2, 1'b0, 64'd10, 64'd10, 64'd0, 64'd0, 1'b0);
        tick("add");
        check("add.dir", bus.result, 64'd20);
        apply(1'b1, 6, 1'b0, 64'd10, 64'd10, 64'd0, 64'd0, 1'b0);
        tick("sub");
        check("sub.zero", {63'd0, bus.zero}, 64'd1);

        // immediate path, logic and shift ops
        apply(1'b1, 1, 1'b1, 64'hF0, 64'hDEAD, 64'h0F, 64'd0, 1'b0);
        tick("or");
        check("or.dir", bus.result, 64'hFF);
        apply(1'b1, 0, 1'b1, 64'hF0, 64'hDEAD, 64'h0F, 64'd0, 1'b0);
        tick("and");
        check("and.dir", bus.result, 64'd0);
        apply(1'b1, 4, 1'b1, 64'd1, 64'd0, 64'h43, 64'd0, 1'b0);
        tick("sll");
        check("sll.dir", bus.result, 64'd8);
        apply(1'b1, 7, 1'b1, '1, 64'd0, 64'd1, 64'd0, 1'b0);
        tick("slt");
        check("slt.dir", bus.result, 64'd1);

        // branches
        apply(1'b1, 6, 1'b0, 64'd5, 64'd5, 64'h8, 64'h100, 1'b1);
        tick("br_taken");
        check("br_taken.next", bus.next_pc, 64'h110);
        apply(1'b1, 6, 1'b0, 64'd5, 64'd6, 64'h8, 64'h100, 1'b1);
        tick("br_not");
        check("br_not.next", bus.next_pc, 64'h104);
        apply(1'b1, 6, 1'b0, 64'd5, 64'd5, -64'sd4, 64'h100, 1'b1);
        tick("br_back");
        check("br_back.target", bus.branch_target, 64'hF8);
        apply(1'b1, 6, 1'b0, 64'd5, 64'd5, 64'h8, 64'h100, 1'b0);
        tick("br_none");
        check("br_none.next", bus.next_pc, 64'h104);

        // wrap-around
        apply(1'b1, 2, 1'b0, '1, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        tick("wrap");
        check("wrap.result", bus.result, 64'd0);
        check("wrap.pc4", bus.pc_plus4, 64'd0);

        // stall for 3 cycles, then resume
        apply(1'b1, 3, 1'b0, 64'h1234, 64'h00FF, 64'd2, 64'h400, 1'b0);
        tick("pre_stall");
        held = bus.result;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2, 1'b0, rnd64(), rnd64(), rnd64(), rnd64(), 1'b1);
            tick("stall");
        end
        check("stall.held", bus.result, 64'h12CB);
        bus.en = 1'b1;
        tick("resume");

        // randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a;
            int op;
            a  = rnd64();
            op = int'($urandom_range(0, 7));
            apply($urandom_range(0, 3) != 0, op, 1'($urandom_range(0, 1)), a, rnd64(),
                  {{56{1'b0}}, 8'($urandom)} - 64'd128, rnd64(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                bus.rs2_data = a;
                bus.alu_src  = 1'b0;
                bus.alu_op   = 3'b110;
            end
            tick("rand");
            if ($urandom_range(0, 39) == 0)
                async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
